mem_responder: RTL and testbench

Main-memory side of the cache/RAM interface. Accepts line-fill read requests and single-word write-through requests issued by the cache controller FSM, models fixed access latency with a down-counter, and streams a full line back one word per cycle. Returns the `Data_ReadyM` (fill complete) and `Data_Ready` (write-through complete) indications the cache controller waits on.

---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_responder_if.sv | 30 +++
 rtl/mem_array.sv | 23 ++
 rtl/mem_responder.sv | 142 ++++++++++++++
 tb/tb_mem_responder.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory responder
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_WAIT,
        WR_DONE
    } mem_state_t;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bus between cache controller and memory
interface mem_responder_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 2
);
    logic              req_valid;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [IDX_W-1:0]  rsp_word_idx;
    logic              Data_ReadyM;
    logic              Data_Ready;
    logic              busy;

    modport master (
        output req_valid, req_rw, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_word_idx,
               Data_ReadyM, Data_Ready, busy
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_word_idx,
               Data_ReadyM, Data_Ready, busy
    );
endinterface

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port synchronous RAM, contents survive reset
module mem_array #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Write when enabled; registered read of the same address every cycle
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency line-fill / write-through memory responder
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int LATENCY        = 3
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    localparam int IDX_W = $clog2(WORDS_PER_LINE);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

    mem_state_t        state;
    logic [CNT_W-1:0]  lat_cnt;
    logic [IDX_W-1:0]  word_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rsp_valid_q;
    logic              drm_q;
    logic              dr_q;
    logic              ready_q;

    logic [IDX_W-1:0]  rd_idx;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_rdata;

    // Array port steering: reads run one word ahead of the word being presented
    // so the registered RAM output lines up with rsp_valid; the word index wraps
    // inside the line and never carries into the line base.
    always_comb begin
        rd_idx   = '0;
        arr_we   = 1'b0;
        arr_addr = '0;
        if (state == RD_BURST) begin
            rd_idx = word_cnt + IDX_W'(1);
        end
        if (state == WR_WAIT) begin
            arr_we   = (lat_cnt == '0);
            arr_addr = addr_q;
        end else begin
            arr_addr = {addr_q[ADDR_W-1:IDX_W], rd_idx};
        end
    end

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    // Request FSM with latency countdown, burst word counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            word_cnt    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            drm_q       <= 1'b0;
            dr_q        <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        lat_cnt <= CNT_LOAD;
                        ready_q <= 1'b0;
                        wdata_q <= bus.req_wdata;
                        if (bus.req_rw == REQ_WRITE) begin
                            state  <= WR_WAIT;
                            addr_q <= bus.req_addr;
                        end else begin
                            state  <= RD_WAIT;
                            addr_q <= {bus.req_addr[ADDR_W-1:IDX_W], {IDX_W{1'b0}}};
                        end
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == '0) begin
                        state       <= RD_BURST;
                        rsp_valid_q <= 1'b1;
                        word_cnt    <= '0;
                        drm_q       <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt - CNT_W'(1);
                    end
                end
                RD_BURST: begin
                    if (word_cnt == LAST_IDX) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        drm_q       <= 1'b0;
                        word_cnt    <= '0;
                        ready_q     <= 1'b1;
                    end else begin
                        word_cnt <= rd_idx;
                        drm_q    <= (rd_idx == LAST_IDX);
                    end
                end
                WR_WAIT: begin
                    if (lat_cnt == '0) begin
                        state <= WR_DONE;
                        dr_q  <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - CNT_W'(1);
                    end
                end
                WR_DONE: begin
                    state   <= IDLE;
                    dr_q    <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = ready_q;
    assign bus.busy         = ~ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_valid_q ? arr_rdata : '0;
    assign bus.rsp_word_idx = word_cnt;
    assign bus.Data_ReadyM  = drm_q;
    assign bus.Data_Ready   = dr_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(10), .DATA_W(32), .IDX_W(2)) b1 ();
    mem_responder_if #(.ADDR_W(10), .DATA_W(32), .IDX_W(3)) b2 ();

    mem_responder #(.ADDR_W(10), .DATA_W(32), .WORDS_PER_LINE(4), .LATENCY(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    mem_responder #(.ADDR_W(10), .DATA_W(32), .WORDS_PER_LINE(8), .LATENCY(1)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (b2)
    );

    typedef struct packed {
        logic       valid;
        logic       drm;
        logic       dr;
        logic       ready;
        logic       busy;
        logic [2:0] idx;
        logic [31:0] data;
    } obs_t;

    typedef struct {
        bit          sel;
        bit          rw;
        logic [9:0]  addr;
        logic [31:0] wdata;
        bit          noise;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model1 [int];
    logic [31:0] model2 [int];
    logic [31:0] last_burst [8];
    vec_t vecs [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic obs_t sample(input bit sel);
        obs_t o;
        if (sel) begin
            o.valid = b2.rsp_valid;   o.drm  = b2.Data_ReadyM; o.dr = b2.Data_Ready;
            o.ready = b2.req_ready;   o.busy = b2.busy;
            o.idx   = b2.rsp_word_idx; o.data = b2.rsp_data;
        end else begin
            o.valid = b1.rsp_valid;   o.drm  = b1.Data_ReadyM; o.dr = b1.Data_Ready;
            o.ready = b1.req_ready;   o.busy = b1.busy;
            o.idx   = {1'b0, b1.rsp_word_idx}; o.data = b1.rsp_data;
        end
        return o;
    endfunction

    task automatic drive(input bit sel, input logic v, input logic rw,
                         input logic [9:0] a, input logic [31:0] d);
        if (sel) begin
            b2.req_valid = v; b2.req_rw = rw; b2.req_addr = a; b2.req_wdata = d;
        end else begin
            b1.req_valid = v; b1.req_rw = rw; b1.req_addr = a; b1.req_wdata = d;
        end
    endtask

    task automatic check_reset_vals(input string name, input bit sel);
        obs_t o, e;
        o = sample(sel);
        e = '0;
        e.ready = 1'b1;
        check(name, 64'(o), 64'(e));
    endtask

    function automatic logic [31:0] mget(input bit sel, input logic [9:0] a);
        if (sel) return model2.exists(int'(a)) ? model2[int'(a)] : 32'hx;
        return model1.exists(int'(a)) ? model1[int'(a)] : 32'hx;
    endfunction

    // One request on the selected DUT, checked cycle by cycle against the timing rules
    task automatic run_req(input int vi, input bit sel, input bit rw, input logic [9:0] addr,
                           input logic [31:0] wdata, input bit noise);
        int lat, n, total;
        logic [9:0] base;
        obs_t o;
        logic exp_valid;
        lat   = sel ? 1 : 3;
        n     = sel ? 8 : 4;
        total = rw ? lat + 1 : lat + n;
        base  = addr & ~(10'(n - 1));
        @(negedge clk);
        o = sample(sel);
        check($sformatf("v%0d ready_before", vi), 64'(o.ready), 64'(1));
        drive(sel, 1'b1, rw, addr, wdata);
        @(posedge clk);
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            drive(sel, 1'b0, 1'b0, 10'h0, 32'h0);
            if (noise && !rw && c >= lat && c < lat + n - 1)
                drive(sel, 1'b1, REQ_WRITE, 10'h020, 32'hBAD0_BAD0);
            o = sample(sel);
            exp_valid = !rw && c >= lat && c < lat + n;
            check($sformatf("v%0d c%0d ctrl", vi, c),
                  64'({o.valid, o.drm, o.dr, o.ready, o.busy}),
                  64'({exp_valid, !rw && c == lat + n - 1, rw && c == lat, 1'b0, 1'b1}));
            if (exp_valid) begin
                check($sformatf("v%0d c%0d idx", vi, c), 64'(o.idx), 64'(c - lat));
                check($sformatf("v%0d c%0d data", vi, c), 64'(o.data),
                      64'(mget(sel, base + 10'(c - lat))));
                last_burst[c - lat] = o.data;
            end
        end
        @(negedge clk);
        o = sample(sel);
        check($sformatf("v%0d ready_after", vi), 64'({o.ready, o.busy, o.valid}), 64'(3'b100));
        if (rw) begin
            if (sel) model2[int'(addr)] = wdata;
            else     model1[int'(addr)] = wdata;
        end
    endtask

    initial begin
        obs_t o;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);

        // reset held for 3 cycles
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset_hold_dut", 0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("reset_release_dut", 0);
        check_reset_vals("reset_release_dut2", 1);

        vecs.push_back('{0, 1, 10'h010, 32'h1111_0000, 0});
        vecs.push_back('{0, 1, 10'h011, 32'h2222_0001, 0});
        vecs.push_back('{0, 1, 10'h012, 32'hA5A5_0001, 0});
        vecs.push_back('{0, 1, 10'h013, 32'h4444_0003, 0});
        vecs.push_back('{0, 0, 10'h013, 32'h0, 0});
        for (int k = 0; k < 4; k++) vecs.push_back('{0, 1, 10'h020 + 10'(k), 32'h2000_0000 + k, 0});
        vecs.push_back('{0, 0, 10'h021, 32'h0, 1});
        vecs.push_back('{0, 0, 10'h020, 32'h0, 0});
        for (int k = 0; k < 4; k++) vecs.push_back('{0, 1, 10'h3FC + 10'(k), 32'hF000_0000 + k, 0});
        vecs.push_back('{0, 0, 10'h3FF, 32'h0, 0});
        for (int k = 0; k < 8; k++) vecs.push_back('{1, 1, 10'h040 + 10'(k), 32'h4000_0000 + k, 0});
        vecs.push_back('{1, 0, 10'h045, 32'h0, 0});

        foreach (vecs[i]) begin
            run_req(i, vecs[i].sel, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].noise);
            if (i == 4)  check("fill_idx2_written_word", 64'(last_burst[2]), 64'(32'hA5A5_0001));
            if (i == 10) check("busy_ignore_old_data", 64'(last_burst[0]), 64'(32'h2000_0000));
            if (i == 15) check("top_line_no_carry", 64'(last_burst[0]), 64'(32'hF000_0000));
            if (i == 24) check("sweep_word7", 64'(last_burst[7]), 64'(32'h4000_0007));
        end

        // back-to-back: read then write held on req_valid
        @(negedge clk);
        drive(0, 1, REQ_READ, 10'h010, 32'h0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1, REQ_WRITE, 10'h015, 32'h5555_0015);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            o = sample(0);
            if (c == 6) check("b2b_read_last", 64'({o.valid, o.drm}), 64'(2'b11));
            if (c == 7) check("b2b_ready_at_LN", 64'(o.ready), 64'(1));
            if (c == 8) begin
                check("b2b_accepted", 64'({o.ready, o.busy}), 64'(2'b01));
                drive(0, 0, 0, 0, 0);
            end
            if (c >= 7) check($sformatf("b2b_wr c%0d", c), 64'({o.valid, o.dr}), 64'({1'b0, c == 11}));
            if (c == 12) check("b2b_ready_after_wr", 64'(o.ready), 64'(1));
        end
        model1[int'(10'h015)] = 32'h5555_0015;

        // reset one cycle into WR_WAIT aborts the write
        @(negedge clk);
        drive(0, 1, REQ_WRITE, 10'h011, 32'hFFFF_FFFF);
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_vals("reset_mid_write", 0);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            o = sample(0);
            check($sformatf("abort_no_dr c%0d", c), 64'({o.dr, o.ready}), 64'(2'b01));
        end
        run_req(100, 0, REQ_READ, 10'h011, 32'h0, 0);
        check("abort_word_unchanged", 64'(last_burst[1]), 64'(32'h2222_0001));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
